layer_next_window_read_gen: RTL and testbench

// - Read-side address sequencer for the next CNN layer. Sweeps the former layer's

---
 rtl/cnn_layer_pkg.sv | 30 +++
 rtl/window_index_counter.sv | 113 +++++++++++
 rtl/layer_next_window_read_gen.sv | 131 +++++++++++++
 tb/tb_layer_next_window_read_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_pkg.sv
// Shared types and elaboration-time helpers for the CNN inter-layer read sequencers.
package cnn_layer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Per-issue tag carried alongside the read until the RAM data returns.
  typedef struct packed {
    logic rd_a;
    logic rd_b;
    logic first;
    logic last;
  } rd_tag_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r > 0) ? r : 1;
  endfunction

  function automatic int out_dim(input int fmap, input int k, input int s);
    return (fmap - k) / s + 1;
  endfunction

endpackage

// File: rtl/window_index_counter.sv
// Walks window pixels two at a time (oy, ox, then in-window index) and keeps the
// matching RAM addresses in incremental base registers instead of multipliers.
module window_index_counter
  import cnn_layer_pkg::*;
#(
  parameter int FMAP_W = 16,
  parameter int FMAP_H = 16,
  parameter int KERNEL = 3,
  parameter int STRIDE = 1,
  parameter int AW     = 9
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          advance,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic          b_valid,
  output logic          first,
  output logic          last,
  output logic          map_last
);

  localparam int OUT_W    = out_dim(FMAP_W, KERNEL, STRIDE);
  localparam int OUT_H    = out_dim(FMAP_H, KERNEL, STRIDE);
  localparam int P        = KERNEL * KERNEL;
  localparam int LAST_PIX = (P >= 2) ? P - 2 : 0;
  localparam int CW       = clog2(FMAP_W + FMAP_H + P + 2);

  localparam logic [AW-1:0] ROW_WRAP = AW'(FMAP_W - KERNEL + 1);
  localparam logic [AW-1:0] X_STEP   = AW'(STRIDE);
  localparam logic [AW-1:0] Y_STEP   = AW'(STRIDE * FMAP_W);
  localparam logic [CW-1:0] K_LAST   = CW'(KERNEL - 1);

  logic [CW-1:0] ox_q, ox_d, oy_q, oy_d, kx_q, kx_d, pix_q, pix_d;
  logic [AW-1:0] row_base_q, row_base_d, win_base_q, win_base_d, addr_q, addr_d;
  logic [CW-1:0] kx_b, kx_n;
  logic [AW-1:0] addr_b_raw, addr_n;
  logic          win_x_last;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
    ox_d       = ox_q;
    oy_d       = oy_q;
    kx_d       = kx_q;
    pix_d      = pix_q;
    row_base_d = row_base_q;
    win_base_d = win_base_q;
    addr_d     = addr_q;

    // Port b sits one pixel past port a; the next port-a pixel is one further.
    kx_b       = (kx_q == K_LAST) ? '0 : kx_q + 1'b1;
    addr_b_raw = (kx_q == K_LAST) ? addr_q + ROW_WRAP : addr_q + 1'b1;
    kx_n       = (kx_b == K_LAST) ? '0 : kx_b + 1'b1;
    addr_n     = (kx_b == K_LAST) ? addr_b_raw + ROW_WRAP : addr_b_raw + 1'b1;

    win_x_last = (ox_q == CW'(OUT_W - 1));
    first      = (pix_q == '0);
    last       = (pix_q >= CW'(LAST_PIX));
    b_valid    = (pix_q < CW'(P - 1));
    map_last   = last && win_x_last && (oy_q == CW'(OUT_H - 1));

    if (advance) begin
      if (!last) begin
        pix_d  = pix_q + CW'(2);
        kx_d   = kx_n;
        addr_d = addr_n;
      end else begin
        pix_d = '0;
        kx_d  = '0;
        if (map_last) begin
          ox_d       = '0;
          oy_d       = '0;
          row_base_d = '0;
          win_base_d = '0;
        end else if (win_x_last) begin
          ox_d       = '0;
          oy_d       = oy_q + 1'b1;
          row_base_d = row_base_q + Y_STEP;
          win_base_d = row_base_d;
        end else begin
          ox_d       = ox_q + 1'b1;
          win_base_d = win_base_q + X_STEP;
        end
        addr_d = win_base_d;
      end
    end
  end

  assign addr_a = addr_q;
  assign addr_b = addr_b_raw;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      ox_q       <= '0;
      oy_q       <= '0;
      kx_q       <= '0;
      pix_q      <= '0;
      row_base_q <= '0;
      win_base_q <= '0;
      addr_q     <= '0;
    end else begin
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      kx_q       <= kx_d;
      pix_q      <= pix_d;
      row_base_q <= row_base_d;
      win_base_q <= win_base_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: rtl/layer_next_window_read_gen.sv
// Next-layer read sequencer: FSM, issue gate, registered RAM read ports and the
// RAM-latency tag pipeline that marks returning window pixels.
module layer_next_window_read_gen
  import cnn_layer_pkg::*;
#(
  parameter int LAYER_FORMER_INFEATURE_ADDR_WIDTH = 9,
  parameter int FMAP_W      = 16,
  parameter int FMAP_H      = 16,
  parameter int KERNEL      = 3,
  parameter int STRIDE      = 1,
  parameter int RAM_LATENCY = 2
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         enable,
  input  logic                                         stall,
  output logic                                         rden_a_layer_next,
  output logic                                         rden_b_layer_next,
  output logic                                         wren_a_layer_next,
  output logic                                         wren_b_layer_next,
  output logic [LAYER_FORMER_INFEATURE_ADDR_WIDTH-1:0] address_a_layer_next,
  output logic [LAYER_FORMER_INFEATURE_ADDR_WIDTH-1:0] address_b_layer_next,
  output logic                                         pix_valid_a,
  output logic                                         pix_valid_b,
  output logic                                         window_first,
  output logic                                         window_last,
  output logic                                         layer_next_done
);

  localparam int AW = LAYER_FORMER_INFEATURE_ADDR_WIDTH;
  localparam int DW = clog2(RAM_LATENCY + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RAM_LATENCY);

  if (FMAP_W * FMAP_H > 2 ** AW) begin : g_addr_check
    $error("feature map does not fit LAYER_FORMER_INFEATURE_ADDR_WIDTH");
  end

  state_e                     state_q, state_d;
  logic [DW-1:0]              drain_q, drain_d;
  rd_tag_t                    issue_q, issue_d;
  rd_tag_t [RAM_LATENCY-1:0]  pipe_q, pipe_d;
  logic [AW-1:0]              addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [AW-1:0]              cnt_addr_a, cnt_addr_b;
  logic                       cnt_b_valid, cnt_first, cnt_last, cnt_map_last;
  logic                       issue;

  assign issue = (state_q == READ) && enable && !stall;

  window_index_counter #(
    .FMAP_W (FMAP_W),
    .FMAP_H (FMAP_H),
    .KERNEL (KERNEL),
    .STRIDE (STRIDE),
    .AW     (AW)
  ) u_window_index_counter (
    .clock    (clock),
    .reset    (reset),
    .advance  (issue),
    .addr_a   (cnt_addr_a),
    .addr_b   (cnt_addr_b),
    .b_valid  (cnt_b_valid),
    .first    (cnt_first),
    .last     (cnt_last),
    .map_last (cnt_map_last)
  );

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    issue_d  = '0;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;

    case (state_q)
      IDLE:    if (enable) state_d = READ;
      READ: begin
        if (issue && cnt_map_last) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else                       drain_d = drain_q + 1'b1;
      end
      default: ;
    endcase

    if (issue) begin
      issue_d  = '{rd_a: 1'b1, rd_b: cnt_b_valid, first: cnt_first, last: cnt_last};
      addr_a_d = cnt_addr_a;
      addr_b_d = cnt_b_valid ? cnt_addr_b : '0;
    end

    // The tag pipeline advances every cycle, independent of stall and enable.
    pipe_d[0] = issue_q;
    for (int k = 1; k < RAM_LATENCY; k++) pipe_d[k] = pipe_q[k-1];
  end

  always_ff @(posedge clock) begin
    // NOTE: the tag pipeline is control state and must be cleared so no stale pixel is flagged; a data-only memory would not need a reset.
    if (reset) begin
      state_q  <= IDLE;
      drain_q  <= '0;
      issue_q  <= '0;
      pipe_q   <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      issue_q  <= issue_d;
      pipe_q   <= pipe_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
    end
  end

  assign rden_a_layer_next    = issue_q.rd_a;
  assign rden_b_layer_next    = issue_q.rd_b;
  assign wren_a_layer_next    = 1'b0;
  assign wren_b_layer_next    = 1'b0;
  assign address_a_layer_next = addr_a_q;
  assign address_b_layer_next = addr_b_q;
  assign pix_valid_a          = pipe_q[RAM_LATENCY-1].rd_a;
  assign pix_valid_b          = pipe_q[RAM_LATENCY-1].rd_b;
  assign window_first         = pipe_q[RAM_LATENCY-1].first;
  assign window_last          = pipe_q[RAM_LATENCY-1].last;
  assign layer_next_done      = (state_q == DONE);

endmodule

// File: tb/tb_layer_next_window_read_gen.sv
// Bench for layer_next_window_read_gen: three geometries checked against an
// arithmetic window-walk model, with a q=address RAM model on the read ports.
module tb_layer_next_window_read_gen;

  localparam int NCFG = 3;
  localparam int AW   = 9;
  localparam int LAT  = 2;
  localparam int CFG_W [NCFG] = '{4, 5, 2};
  localparam int CFG_K [NCFG] = '{3, 3, 2};
  localparam int CFG_S [NCFG] = '{1, 2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NCFG-1:0] rst, en, stall;
  logic [NCFG-1:0] rden_a, rden_b, wren_a, wren_b, pix_valid_a, pix_valid_b;
  logic [NCFG-1:0] w_first, w_last, done;
  logic [NCFG-1:0][AW-1:0] addr_a, addr_b;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    layer_next_window_read_gen #(
      .LAYER_FORMER_INFEATURE_ADDR_WIDTH (AW),
      .FMAP_W      (CFG_W[g]),
      .FMAP_H      (CFG_W[g]),
      .KERNEL      (CFG_K[g]),
      .STRIDE      (CFG_S[g]),
      .RAM_LATENCY (LAT)
    ) u_dut (
      .clock                (clk),
      .reset                (rst[g]),
      .enable               (en[g]),
      .stall                (stall[g]),
      .rden_a_layer_next    (rden_a[g]),
      .rden_b_layer_next    (rden_b[g]),
      .wren_a_layer_next    (wren_a[g]),
      .wren_b_layer_next    (wren_b[g]),
      .address_a_layer_next (addr_a[g]),
      .address_b_layer_next (addr_b[g]),
      .pix_valid_a          (pix_valid_a[g]),
      .pix_valid_b          (pix_valid_b[g]),
      .window_first         (w_first[g]),
      .window_last          (w_last[g]),
      .layer_next_done      (done[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference model: pure geometry arithmetic.
  function automatic int out_w(input int g);
    return (CFG_W[g] - CFG_K[g]) / CFG_S[g] + 1;
  endfunction
  function automatic int pix_per_win(input int g);
    return CFG_K[g] * CFG_K[g];
  endfunction
  function automatic int pairs_per_win(input int g);
    return (pix_per_win(g) + 1) / 2;
  endfunction
  function automatic int n_issues(input int g);
    return out_w(g) * out_w(g) * pairs_per_win(g);
  endfunction
  // Address of the j-th pixel in the full window walk.
  function automatic int ref_pix(input int g, input int j);
    int p, win, i, ox, oy;
    p   = pix_per_win(g);
    win = j / p;
    i   = j % p;
    ox  = win % out_w(g);
    oy  = win / out_w(g);
    return (oy * CFG_S[g] + i / CFG_K[g]) * CFG_W[g] + ox * CFG_S[g] + i % CFG_K[g];
  endfunction
  // Walk index of the port-a pixel of the n-th issue.
  function automatic int iss_pix(input int g, input int n);
    return (n / pairs_per_win(g)) * pix_per_win(g) + 2 * (n % pairs_per_win(g));
  endfunction

  int iss_idx [NCFG];
  int pix_idx [NCFG];
  int last_rd [NCFG];
  int cyc = 0;
  logic [LAT-1:0] dly_a [NCFG];
  logic [LAT-1:0] dly_b [NCFG];
  logic [LAT-1:0][AW-1:0] dly_qa [NCFG];
  logic [LAT-1:0][AW-1:0] dly_qb [NCFG];

  always @(negedge clk) begin
    for (int g = 0; g < NCFG; g++) begin
      if (rst[g]) begin
        iss_idx[g] = 0;
        pix_idx[g] = 0;
        last_rd[g] = -1000;
        dly_a[g]   = '0;
        dly_b[g]   = '0;
        dly_qa[g]  = '0;
        dly_qb[g]  = '0;
      end else begin
        int  p, pa, j;
        logic bv;
        p = pix_per_win(g);
        check($sformatf("cfg%0d wren", g), {wren_a[g], wren_b[g]}, 0);
        if (rden_a[g]) begin
          if (iss_idx[g] >= n_issues(g)) begin
            check($sformatf("cfg%0d extra issue", g), iss_idx[g], n_issues(g) - 1);
          end else begin
            pa = iss_pix(g, iss_idx[g]);
            bv = ((pa % p) + 1) < p;
            check($sformatf("cfg%0d addr_a #%0d", g, iss_idx[g]), addr_a[g], ref_pix(g, pa));
            check($sformatf("cfg%0d rden_b #%0d", g, iss_idx[g]), rden_b[g], bv);
            check($sformatf("cfg%0d addr_b #%0d", g, iss_idx[g]), addr_b[g], bv ? ref_pix(g, pa + 1) : 0);
          end
          iss_idx[g]++;
          last_rd[g] = cyc;
        end else begin
          check($sformatf("cfg%0d rden_b idle", g), rden_b[g], 0);
        end
        check($sformatf("cfg%0d done", g), done[g],
              (iss_idx[g] == n_issues(g)) && (cyc - last_rd[g] >= 3));
        check($sformatf("cfg%0d pix_valid_a", g), pix_valid_a[g], dly_a[g][LAT-1]);
        check($sformatf("cfg%0d pix_valid_b", g), pix_valid_b[g], dly_b[g][LAT-1]);
        if (dly_a[g][LAT-1]) begin
          j = pix_idx[g];
          check($sformatf("cfg%0d q_a pix%0d", g, j), dly_qa[g][LAT-1], ref_pix(g, j));
          check($sformatf("cfg%0d first pix%0d", g, j), w_first[g], (j % p) == 0);
          check($sformatf("cfg%0d last pix%0d", g, j), w_last[g], (j % p) >= p - 2);
          pix_idx[g]++;
          if (dly_b[g][LAT-1]) begin
            check($sformatf("cfg%0d q_b pix%0d", g, pix_idx[g]), dly_qb[g][LAT-1], ref_pix(g, pix_idx[g]));
            pix_idx[g]++;
          end
        end else begin
          check($sformatf("cfg%0d first/last idle", g), {w_first[g], w_last[g]}, 0);
        end
        dly_a[g]  = {dly_a[g][LAT-2:0], rden_a[g]};
        dly_b[g]  = {dly_b[g][LAT-2:0], rden_b[g]};
        dly_qa[g] = {dly_qa[g][LAT-2:0], addr_a[g]};
        dly_qb[g] = {dly_qb[g][LAT-2:0], addr_b[g]};
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input int g);
    rst[g] = 1'b1;
    tick();
    rst[g] = 1'b0;
  endtask

  function automatic logic [31:0] out_bits(input int g);
    return {rden_a[g], rden_b[g], wren_a[g], wren_b[g], pix_valid_a[g], pix_valid_b[g],
            w_first[g], w_last[g], done[g], addr_a[g], addr_b[g]};
  endfunction

  initial begin
    int n;
    rst   = '1;
    en    = '0;
    stall = '0;

    // Model pins: hand-computed window walks.
    check("pin w0 a", {ref_pix(0, 0), ref_pix(0, 2), ref_pix(0, 4), ref_pix(0, 6), ref_pix(0, 8)},
          {32'd0, 32'd2, 32'd5, 32'd8, 32'd10});
    check("pin w0 b", {ref_pix(0, 1), ref_pix(0, 3), ref_pix(0, 5), ref_pix(0, 7)},
          {32'd1, 32'd4, 32'd6, 32'd9});
    check("pin s2 windows", {ref_pix(1, 0), ref_pix(1, 9), ref_pix(1, 18), ref_pix(1, 27)},
          {32'd0, 32'd2, 32'd10, 32'd12});
    check("pin issue counts", {n_issues(0), n_issues(1), n_issues(2)}, {32'd20, 32'd20, 32'd2});
    check("pin degenerate", {ref_pix(2, 0), ref_pix(2, 1), ref_pix(2, 2), ref_pix(2, 3)},
          {32'd0, 32'd1, 32'd2, 32'd3});

    repeat (3) tick();
    rst = '0;
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) check($sformatf("cfg%0d reset outputs", g), out_bits(g), 0);

    // Basic, stride-2 and degenerate sweeps with enable held.
    tick();
    en = '1;
    for (n = 0; n < 300 && done != '1; n++) tick();
    check("sweep done timeout", done, 3'b111);
    check("cfg0 issues", iss_idx[0], 20);
    check("cfg1 issues", iss_idx[1], 20);
    check("cfg2 issues", iss_idx[2], 2);
    check("cfg0 pixels", pix_idx[0], 36);
    check("cfg1 pixels", pix_idx[1], 36);
    check("cfg2 pixels", pix_idx[2], 4);

    repeat (20) begin
      @(negedge clk);
      check("deg done held", done[2], 1);
    end
    tick();
    en[2] = 1'b0;
    pulse_reset(2);
    @(negedge clk);
    check("deg done cleared", done[2], 0);

    // Pause run: stall toggles every 3 cycles, enable drops for 5 cycles.
    tick();
    en[0] = 1'b0;
    pulse_reset(0);
    for (n = 0; n < 600 && !done[0]; n++) begin
      stall[0] = ((n / 3) % 2) == 1;
      en[0]    = !(n >= 20 && n < 25);
      tick();
    end
    stall[0] = 1'b0;
    en[0]    = 1'b1;
    check("pause done timeout", done[0], 1);
    check("pause issues", iss_idx[0], 20);
    check("pause pixels", pix_idx[0], 36);

    // Reset mid-run after the 7th issue.
    en[0] = 1'b0;
    pulse_reset(0);
    en[0] = 1'b1;
    for (n = 0; n < 100 && iss_idx[0] < 7; n++) tick();
    check("mid reset reach 7", iss_idx[0], 7);
    pulse_reset(0);
    @(negedge clk);
    check("mid reset outputs", out_bits(0), 0);
    tick();
    for (n = 0; n < 300 && !done[0]; n++) tick();
    check("restart done timeout", done[0], 1);
    check("restart issues", iss_idx[0], 20);
    check("restart pixels", pix_idx[0], 36);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
